// File: rtl/vec3_serializer_if.sv
// Handshake bundle between an upstream first-word-fall-through vec3 FIFO
// and a downstream scalar FIFO, as seen by the vec3 serializer.
interface vec3_serializer_if #(
   parameter int D_BITS = 32
);
   logic [D_BITS-1:0] in_dout [2:0];
   logic              in_empty;
   logic              in_rd_en;
   logic [D_BITS-1:0] out_din;
   logic              out_last;
   logic              out_full;
   logic              out_wr_en;

   modport master (
      input  in_dout, in_empty, out_full,
      output in_rd_en, out_din, out_last, out_wr_en
   );

   modport slave (
      output in_dout, in_empty, out_full,
      input  in_rd_en, out_din, out_last, out_wr_en
   );
endinterface

// File: rtl/vec3_serializer.sv
// Pops vec3 words from an upstream FIFO and writes them as three scalar
// components (x[0], x[1], x[2]), flagging the final component of each frame.
module vec3_serializer #(
   parameter int D_BITS    = 32,
   parameter int FRAME_LEN = 16,
   parameter int CNT_BITS  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
   input  logic                clock,
   input  logic                reset,
   vec3_serializer_if.master   bus,
   output logic [CNT_BITS-1:0] vec_idx,
   output logic                busy
);

   typedef enum logic {
      s_idle,
      s_emit
   } state_t;

   localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(FRAME_LEN - 1);

   state_t              state;
   state_t              state_next;
   logic [D_BITS-1:0]   hold [3];
   logic [1:0]          comp;
   logic [1:0]          comp_next;
   logic [CNT_BITS-1:0] vec_idx_next;
   logic                load;

   // Next-state logic; a new vector is loaded on the same cycle as the write
   // of component 2 so a sustained stream runs without bubbles.
   always_comb begin
      state_next   = state;
      comp_next    = comp;
      vec_idx_next = vec_idx;
      load         = 1'b0;
      case (state)
         s_idle: begin
            if (!bus.in_empty) begin
               load       = 1'b1;
               comp_next  = 2'd0;
               state_next = s_emit;
            end
         end
         s_emit: begin
            if (!bus.out_full) begin
               if (comp != 2'd2) begin
                  comp_next = comp + 2'd1;
               end else begin
                  vec_idx_next = (vec_idx == LAST_IDX) ? '0 : vec_idx + 1'b1;
                  comp_next    = 2'd0;
                  if (!bus.in_empty) begin
                     load = 1'b1;
                  end else begin
                     state_next = s_idle;
                  end
               end
            end
         end
         default: state_next = s_idle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= s_idle;
         comp    <= 2'd0;
         vec_idx <= '0;
         for (int k = 0; k < 3; k++) begin
            hold[k] <= '0;
         end
      end else begin
         state   <= state_next;
         comp    <= comp_next;
         vec_idx <= vec_idx_next;
         if (load) begin
            for (int k = 0; k < 3; k++) begin
               hold[k] <= bus.in_dout[k];
            end
         end
      end
   end

   // Outputs come straight from registers so they stay stable through a stall.
   always_comb begin
      case (comp)
         2'd0:    bus.out_din = hold[0];
         2'd1:    bus.out_din = hold[1];
         default: bus.out_din = hold[2];
      endcase
      bus.out_last  = (comp == 2'd2) && (vec_idx == LAST_IDX);
      bus.out_wr_en = (state == s_emit) && !bus.out_full;
      bus.in_rd_en  = load;
      busy          = (state == s_emit);
   end

endmodule

// File: tb/tb_vec3_serializer.sv
// Self-checking bench: two serializers (FRAME_LEN 16 and 2) checked every
// cycle against a queue-level model of the upstream and expected-output streams.
module tb_vec3_serializer;

   localparam int D_BITS    = 32;
   localparam int FL_A      = 16;
   localparam int FL_B      = 2;
   localparam int SRC_DEPTH = 64;
   localparam int EXP_DEPTH = 256;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] vec_idx_a;
   logic [0:0] vec_idx_b;
   logic       busy_a;
   logic       busy_b;

   vec3_serializer_if #(.D_BITS(D_BITS)) bus_a ();
   vec3_serializer_if #(.D_BITS(D_BITS)) bus_b ();

   vec3_serializer #(.D_BITS(D_BITS), .FRAME_LEN(FL_A)) dut_a (
      .clock   (clock),
      .reset   (reset),
      .bus     (bus_a),
      .vec_idx (vec_idx_a),
      .busy    (busy_a)
   );

   vec3_serializer #(.D_BITS(D_BITS), .FRAME_LEN(FL_B)) dut_b (
      .clock   (clock),
      .reset   (reset),
      .bus     (bus_b),
      .vec_idx (vec_idx_b),
      .busy    (busy_b)
   );

   always #5 clock = ~clock;

   logic [3*D_BITS-1:0] src_mem [2][SRC_DEPTH];
   logic [D_BITS:0]     exp_mem [2][EXP_DEPTH];
   int src_rd [2]   = '{0, 0};
   int src_wr [2]   = '{0, 0};
   int exp_rd [2]   = '{0, 0};
   int exp_wr [2]   = '{0, 0};
   int writes [2]   = '{0, 0};
   int popped [2]   = '{0, 0};
   bit full_req [2] = '{1'b0, 1'b0};
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic push_vec(input int d, input logic [D_BITS-1:0] x0,
                           input logic [D_BITS-1:0] x1, input logic [D_BITS-1:0] x2);
      src_mem[d][src_wr[d] % SRC_DEPTH] = {x2, x1, x0};
      src_wr[d]++;
   endtask

   task automatic apply_stimulus();
      logic [3*D_BITS-1:0] head_a;
      logic [3*D_BITS-1:0] head_b;
      head_a = src_mem[0][src_rd[0] % SRC_DEPTH];
      head_b = src_mem[1][src_rd[1] % SRC_DEPTH];
      bus_a.in_empty = (src_rd[0] == src_wr[0]);
      bus_b.in_empty = (src_rd[1] == src_wr[1]);
      for (int k = 0; k < 3; k++) begin
         bus_a.in_dout[k] = head_a[k*D_BITS +: D_BITS];
         bus_b.in_dout[k] = head_b[k*D_BITS +: D_BITS];
      end
      bus_a.out_full = full_req[0];
      bus_b.out_full = full_req[1];
   endtask

   // Model rule: a vector is held while it still has components to emit; a pop
   // is due when nothing is held, or the last held component is leaving now.
   task automatic check_dut(input int d, input int frame_len, input string name,
                            input logic rd_en, input logic wr_en,
                            input logic [D_BITS-1:0] din, input logic last,
                            input int vidx, input logic busy,
                            output bit pop, output bit wr);
      int              pending;
      bit              avail;
      logic [D_BITS:0] head;
      pending = exp_wr[d] - exp_rd[d];
      avail   = (src_rd[d] != src_wr[d]);
      head    = exp_mem[d][exp_rd[d] % EXP_DEPTH];
      wr  = (pending != 0) && !full_req[d];
      pop = avail && ((pending == 0) || ((pending == 1) && !full_req[d]));
      check_output({name, "/in_rd_en"}, 64'(rd_en), 64'(pop));
      check_output({name, "/out_wr_en"}, 64'(wr_en), 64'(wr));
      check_output({name, "/busy"}, 64'(busy), 64'(pending != 0));
      check_output({name, "/vec_idx"}, 64'(vidx), 64'((writes[d] / 3) % frame_len));
      check_output({name, "/rd_when_empty"}, 64'(rd_en && !avail), 64'(0));
      check_output({name, "/wr_when_full"}, 64'(wr_en && full_req[d]), 64'(0));
      if (pending != 0) begin
         check_output({name, "/out_din"}, 64'(din), 64'(head[D_BITS-1:0]));
         check_output({name, "/out_last"}, 64'(last), 64'(head[D_BITS]));
      end
   endtask

   task automatic update_model(input int d, input int frame_len, input bit pop, input bit wr);
      logic [3*D_BITS-1:0] v;
      int                  idx;
      if (wr) begin
         exp_rd[d]++;
         writes[d]++;
      end
      if (pop) begin
         v   = src_mem[d][src_rd[d] % SRC_DEPTH];
         idx = popped[d] % frame_len;
         src_rd[d]++;
         popped[d]++;
         for (int c = 0; c < 3; c++) begin
            exp_mem[d][exp_wr[d] % EXP_DEPTH] = {(c == 2) && (idx == frame_len - 1),
                                                 v[c*D_BITS +: D_BITS]};
            exp_wr[d]++;
         end
      end
   endtask

   task automatic cycle();
      bit pop_a, wr_a, pop_b, wr_b;
      pop_a = 1'b0; wr_a = 1'b0; pop_b = 1'b0; wr_b = 1'b0;
      @(negedge clock);
      apply_stimulus();
      #1;
      if (!reset) begin
         check_dut(0, FL_A, "A", bus_a.in_rd_en, bus_a.out_wr_en, bus_a.out_din,
                   bus_a.out_last, int'(vec_idx_a), busy_a, pop_a, wr_a);
         check_dut(1, FL_B, "B", bus_b.in_rd_en, bus_b.out_wr_en, bus_b.out_din,
                   bus_b.out_last, int'(vec_idx_b), busy_b, pop_b, wr_b);
      end
      @(posedge clock);
      #1;
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            exp_rd[d] = exp_wr[d];
            writes[d] = 0;
            popped[d] = 0;
         end
      end else begin
         update_model(0, FL_A, pop_a, wr_a);
         update_model(1, FL_B, pop_b, wr_b);
      end
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         done = (src_rd[0] == src_wr[0]) && (src_rd[1] == src_wr[1]) &&
                (exp_rd[0] == exp_wr[0]) && (exp_rd[1] == exp_wr[1]);
         if (!done) cycle();
      end
      check_output({tag, "/drain_done"}, 64'(done), 64'(1));
   endtask

   task automatic wait_writes(input int d, input int target, input string tag);
      for (int i = 0; i < 50 && writes[d] < target; i++) cycle();
      check_output({tag, "/write_reached"}, 64'(writes[d]), 64'(target));
   endtask

   initial begin
      int base;
      apply_stimulus();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;

      @(negedge clock);
      apply_stimulus();
      #1;
      check_output("A/reset_out_din", 64'(bus_a.out_din), 64'(0));
      check_output("A/reset_out_last", 64'(bus_a.out_last), 64'(0));
      check_output("B/reset_out_din", 64'(bus_b.out_din), 64'(0));
      check_output("A/reset_vec_idx", 64'(vec_idx_a), 64'(0));
      cycle();

      push_vec(0, 32'd1, 32'd2, 32'd3);
      push_vec(1, 32'hA0, 32'hA1, 32'hA2);
      push_vec(1, 32'hB0, 32'hB1, 32'hB2);
      push_vec(1, 32'hC0, 32'hC1, 32'hC2);
      drain("single_and_frame2");

      push_vec(0, 32'd1, 32'd2, 32'd3);
      push_vec(0, 32'd4, 32'd5, 32'd6);
      drain("back_to_back");

      base = writes[0];
      push_vec(0, 32'd7, 32'd8, 32'd9);
      wait_writes(0, base + 1, "stall_setup");
      full_req[0] = 1'b1;
      repeat (4) cycle();
      full_req[0] = 1'b0;
      drain("stall");

      for (int i = 0; i < 400; i++) begin
         for (int d = 0; d < 2; d++) begin
            full_req[d] = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 2) == 0 && (src_wr[d] - src_rd[d]) < SRC_DEPTH - 2)
               push_vec(d, $urandom, $urandom, $urandom);
         end
         cycle();
      end
      full_req[0] = 1'b0;
      full_req[1] = 1'b0;
      drain("random");

      base = writes[0];
      push_vec(0, 32'd10, 32'd11, 32'd12);
      wait_writes(0, base + 1, "reset_setup");
      reset       = 1'b1;
      full_req[0] = 1'b1;
      cycle();
      reset       = 1'b0;
      full_req[0] = 1'b0;
      push_vec(0, 32'd13, 32'd14, 32'd15);
      drain("after_reset");

      push_vec(0, 32'hFFFF0000, 32'h80000000, 32'h7FFFFFFF);
      push_vec(1, 32'h80000000, 32'h7FFFFFFF, 32'h00000001);
      drain("bit_patterns");
      repeat (10) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
